// File: rtl/systolic_seq_ctrl_pkg.sv
// systolic_seq_ctrl_pkg: state encoding and sizing helpers for the systolic sequencer
package systolic_seq_ctrl_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  function automatic int wd_limit(input int n);
    return 4 * n;
  endfunction
  function automatic int skew_beats(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// skew_line: DEPTH-stage lane delay, DEPTH=0 passes straight through
module skew_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, reset, clr, en};
    assign q = d;
  end else begin : g_reg
    logic [DW-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        sr <= '{default: '0};
      end else if (en) begin
        sr[0] <= d;
        for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: clears, feeds skewed operands to, and drains results from an NxN systolic array
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N  = 32,
  parameter int DW = 8,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          a_rd_en,
  output logic          b_rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW*N-1:0] a_rd_data,
  input  logic [DW*N-1:0] b_rd_data,
  output logic          arr_clear,
  output logic [DW*N-1:0] arr_in_a,
  output logic [DW*N-1:0] arr_in_b,
  output logic          arr_en_in,
  input  logic [DW*N-1:0] arr_out_data,
  input  logic          arr_en_out,
  output logic          res_wr_en,
  output logic [AW-1:0] res_wr_addr,
  output logic [DW*N-1:0] res_wr_data
);
  localparam int WW = $clog2(4 * N) + 1;
  localparam logic [WW-1:0] WD_MAX = WW'(wd_limit(N));
  localparam logic [AW:0] LAST = (AW+1)'(N - 1);
  localparam logic [AW:0] ROWS = (AW+1)'(N);
  logic [2:0] state, nxt;
  logic [AW:0] beat;
  logic [WW-1:0] wd;
  logic rd_v, run, cap, wd_to, drop;
  logic [DW*N-1:0] a_lane, b_lane;
  assign busy      = state != S_IDLE;
  assign done      = state == S_DONE;
  assign arr_clear = state == S_CLEAR;
  assign a_rd_en   = state == S_FEED;
  assign b_rd_en   = a_rd_en;
  assign rd_addr   = a_rd_en ? beat[AW-1:0] : '0;
  assign run       = a_rd_en || state == S_FLUSH || state == S_DRAIN;
  // beat doubles as the feed index in FEED and the captured-row count afterwards
  assign wd_to = state == S_FLUSH && !arr_en_out && wd == WD_MAX;
  assign drop  = state == S_DRAIN && beat != ROWS && !arr_en_out;
  assign cap   = arr_en_out && (state == S_FLUSH || (state == S_DRAIN && beat != ROWS));
  assign err   = wd_to || drop;
  assign a_lane = rd_v ? a_rd_data : '0;
  assign b_lane = rd_v ? b_rd_data : '0;
  always_comb
    nxt = state == S_IDLE  ? (start ? S_CLEAR : S_IDLE) :
          state == S_CLEAR ? S_FEED :
          state == S_FEED  ? (beat == LAST ? S_FLUSH : S_FEED) :
          state == S_FLUSH ? (arr_en_out ? S_DRAIN : wd_to ? S_IDLE : S_FLUSH) :
          state == S_DRAIN ? (beat == ROWS ? S_DONE : drop ? S_IDLE : S_DRAIN) : S_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      beat        <= '0;
      wd          <= '0;
      rd_v        <= 1'b0;
      arr_en_in   <= 1'b0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
    end else begin
      state     <= nxt;
      rd_v      <= a_rd_en;
      arr_en_in <= a_rd_en && beat == '0;
      beat      <= a_rd_en ? (beat == LAST ? '0 : beat + 1'b1) :
                   cap ? beat + 1'b1 :
                   (state == S_FLUSH || state == S_DRAIN) ? beat : '0;
      wd        <= (state == S_IDLE || state == S_CLEAR) ? '0 :
                   arr_en_in ? WW'(1) :
                   state == S_DRAIN ? wd : wd + 1'b1;
      res_wr_en <= cap;
      if (cap) begin
        res_wr_data <= arr_out_data;
        res_wr_addr <= beat[AW-1:0];
      end else if (state == S_DONE) begin
        res_wr_addr <= '0;
      end
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_skew
    skew_line #(.DW(DW), .DEPTH(i)) u_a (
      .clk(clk), .reset(reset), .clr(arr_clear), .en(run),
      .d(a_lane[i*DW +: DW]), .q(arr_in_a[i*DW +: DW])
    );
    skew_line #(.DW(DW), .DEPTH(i)) u_b (
      .clk(clk), .reset(reset), .clr(arr_clear), .en(run),
      .d(b_lane[i*DW +: DW]), .q(arr_in_b[i*DW +: DW])
    );
  end
endmodule
